// File: rtl/tilelink_ul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tilelink_ul_arbiter
// Brief    : Two-master to one-slave TileLink-UL arbiter, round-robin grant,
//            ownership held across all A and D beats of one transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tilelink_ul_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  m0_a_valid,
    output logic                  m0_a_ready,
    input  logic [2:0]            m0_a_bits_opcode,
    input  logic [2:0]            m0_a_bits_param,
    input  logic [3:0]            m0_a_bits_size,
    input  logic                  m0_a_bits_source,
    input  logic [31:0]           m0_a_bits_address,
    input  logic [DATA_W/8-1:0]   m0_a_bits_mask,
    input  logic [DATA_W-1:0]     m0_a_bits_data,
    input  logic                  m0_d_ready,
    output logic                  m0_d_valid,
    output logic [2:0]            m0_d_bits_opcode,
    output logic [1:0]            m0_d_bits_param,
    output logic [3:0]            m0_d_bits_size,
    output logic                  m0_d_bits_source,
    output logic                  m0_d_bits_sink,
    output logic [DATA_W-1:0]     m0_d_bits_data,
    output logic                  m0_d_bits_error,

    input  logic                  m1_a_valid,
    output logic                  m1_a_ready,
    input  logic [2:0]            m1_a_bits_opcode,
    input  logic [2:0]            m1_a_bits_param,
    input  logic [3:0]            m1_a_bits_size,
    input  logic                  m1_a_bits_source,
    input  logic [31:0]           m1_a_bits_address,
    input  logic [DATA_W/8-1:0]   m1_a_bits_mask,
    input  logic [DATA_W-1:0]     m1_a_bits_data,
    input  logic                  m1_d_ready,
    output logic                  m1_d_valid,
    output logic [2:0]            m1_d_bits_opcode,
    output logic [1:0]            m1_d_bits_param,
    output logic [3:0]            m1_d_bits_size,
    output logic                  m1_d_bits_source,
    output logic                  m1_d_bits_sink,
    output logic [DATA_W-1:0]     m1_d_bits_data,
    output logic                  m1_d_bits_error,

    output logic                  s_a_valid,
    input  logic                  s_a_ready,
    output logic [2:0]            s_a_bits_opcode,
    output logic [2:0]            s_a_bits_param,
    output logic [3:0]            s_a_bits_size,
    output logic [1:0]            s_a_bits_source,
    output logic [31:0]           s_a_bits_address,
    output logic [DATA_W/8-1:0]   s_a_bits_mask,
    output logic [DATA_W-1:0]     s_a_bits_data,
    input  logic                  s_d_valid,
    output logic                  s_d_ready,
    input  logic [2:0]            s_d_bits_opcode,
    input  logic [1:0]            s_d_bits_param,
    input  logic [3:0]            s_d_bits_size,
    input  logic [1:0]            s_d_bits_source,
    input  logic                  s_d_bits_sink,
    input  logic [DATA_W-1:0]     s_d_bits_data,
    input  logic                  s_d_bits_error,

    output logic                  owner,
    output logic                  busy,
    output logic                  protocol_err
);
    localparam int LG_BEAT = $clog2(DATA_W / 8);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_A_BEATS = 2'd1;
    localparam logic [1:0] S_D_BEATS = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] a_left_q, a_left_d;
    logic [CNT_W-1:0] d_left_q, d_left_d;
    logic             perr_q, perr_d;

    function automatic logic [CNT_W-1:0] beats(input logic [3:0] size);
        if (size <= 4'(LG_BEAT)) beats = CNT_W'(1);
        else                     beats = CNT_W'(1) << (size - 4'(LG_BEAT));
    endfunction

    logic             w_win, w_sel, w_a_open, w_dsel;
    logic             w_a_fire, w_d_fire, w_d_count, w_stray;
    logic [CNT_W-1:0] w_a_beats, w_d_beats;

    assign w_win    = (m0_a_valid && m1_a_valid) ? prio_q : m1_a_valid;
    assign w_sel    = (state_q == S_IDLE) ? w_win : owner_q;
    assign w_a_open = (state_q != S_D_BEATS);

    assign s_a_valid  = !reset && w_a_open && (w_sel ? m1_a_valid : m0_a_valid);
    assign m0_a_ready = !reset && w_a_open && !w_sel && s_a_ready;
    assign m1_a_ready = !reset && w_a_open &&  w_sel && s_a_ready;

    assign s_a_bits_opcode  = w_sel ? m1_a_bits_opcode  : m0_a_bits_opcode;
    assign s_a_bits_param   = w_sel ? m1_a_bits_param   : m0_a_bits_param;
    assign s_a_bits_size    = w_sel ? m1_a_bits_size    : m0_a_bits_size;
    assign s_a_bits_source  = {w_sel, (w_sel ? m1_a_bits_source : m0_a_bits_source)};
    assign s_a_bits_address = w_sel ? m1_a_bits_address : m0_a_bits_address;
    assign s_a_bits_mask    = w_sel ? m1_a_bits_mask    : m0_a_bits_mask;
    assign s_a_bits_data    = w_sel ? m1_a_bits_data    : m0_a_bits_data;

    // D responses are steered purely by the tag, independent of arbiter state.
    assign w_dsel     = s_d_bits_source[1];
    assign m0_d_valid = !reset && s_d_valid && !w_dsel;
    assign m1_d_valid = !reset && s_d_valid &&  w_dsel;
    assign s_d_ready  = !reset && (w_dsel ? m1_d_ready : m0_d_ready);

    assign m0_d_bits_opcode = s_d_bits_opcode;
    assign m0_d_bits_param  = s_d_bits_param;
    assign m0_d_bits_size   = s_d_bits_size;
    assign m0_d_bits_source = s_d_bits_source[0];
    assign m0_d_bits_sink   = s_d_bits_sink;
    assign m0_d_bits_data   = s_d_bits_data;
    assign m0_d_bits_error  = s_d_bits_error;
    assign m1_d_bits_opcode = s_d_bits_opcode;
    assign m1_d_bits_param  = s_d_bits_param;
    assign m1_d_bits_size   = s_d_bits_size;
    assign m1_d_bits_source = s_d_bits_source[0];
    assign m1_d_bits_sink   = s_d_bits_sink;
    assign m1_d_bits_data   = s_d_bits_data;
    assign m1_d_bits_error  = s_d_bits_error;

    assign w_a_fire  = s_a_valid && s_a_ready;
    assign w_d_fire  = s_d_valid && s_d_ready;
    assign w_d_count = w_d_fire && (state_q == S_D_BEATS) && (w_dsel == owner_q);
    assign w_stray   = w_d_fire && !w_d_count;

    assign w_a_beats = (s_a_bits_opcode <= 3'd3) ? beats(s_a_bits_size) : CNT_W'(1);
    assign w_d_beats = (s_a_bits_opcode >= 3'd2 && s_a_bits_opcode <= 3'd4)
                       ? beats(s_a_bits_size) : CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        a_left_d = a_left_q;
        d_left_d = d_left_q;
        perr_d   = perr_q | w_stray;
        case (state_q)
            S_IDLE: begin
                if (w_a_fire) begin
                    owner_d  = w_sel;
                    // D count is taken from the first beat and parked until A completes.
                    d_left_d = w_d_beats;
                    if (w_a_beats > CNT_W'(1)) begin
                        state_d  = S_A_BEATS;
                        a_left_d = w_a_beats - CNT_W'(1);
                    end else begin
                        state_d  = S_D_BEATS;
                    end
                end
            end
            S_A_BEATS: begin
                if (w_a_fire) begin
                    a_left_d = a_left_q - CNT_W'(1);
                    if (a_left_q == CNT_W'(1)) state_d = S_D_BEATS;
                end
            end
            S_D_BEATS: begin
                if (w_d_count) begin
                    d_left_d = d_left_q - CNT_W'(1);
                    if (d_left_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        prio_d  = ~owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            a_left_q <= '0;
            d_left_q <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            a_left_q <= a_left_d;
            d_left_q <= d_left_d;
            perr_q   <= perr_d;
        end
    end

    assign owner        = owner_q;
    assign busy         = (state_q != S_IDLE);
    assign protocol_err = perr_q;
endmodule
`default_nettype wire

// File: tb/tb_tilelink_ul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tilelink_ul_arbiter
// Brief    : Self-checking bench: vector table, directed sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tilelink_ul_arbiter;
    localparam int DATA_W = 32;
    localparam int BB     = DATA_W / 8;
    localparam int LG     = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic m0_a_valid, m0_a_ready, m0_a_bits_source, m0_d_ready, m0_d_valid;
    logic [2:0] m0_a_bits_opcode, m0_a_bits_param;
    logic [3:0] m0_a_bits_size;
    logic [31:0] m0_a_bits_address;
    logic [BB-1:0] m0_a_bits_mask;
    logic [DATA_W-1:0] m0_a_bits_data, m0_d_bits_data;
    logic [2:0] m0_d_bits_opcode; logic [1:0] m0_d_bits_param; logic [3:0] m0_d_bits_size;
    logic m0_d_bits_source, m0_d_bits_sink, m0_d_bits_error;

    logic m1_a_valid, m1_a_ready, m1_a_bits_source, m1_d_ready, m1_d_valid;
    logic [2:0] m1_a_bits_opcode, m1_a_bits_param;
    logic [3:0] m1_a_bits_size;
    logic [31:0] m1_a_bits_address;
    logic [BB-1:0] m1_a_bits_mask;
    logic [DATA_W-1:0] m1_a_bits_data, m1_d_bits_data;
    logic [2:0] m1_d_bits_opcode; logic [1:0] m1_d_bits_param; logic [3:0] m1_d_bits_size;
    logic m1_d_bits_source, m1_d_bits_sink, m1_d_bits_error;

    logic s_a_valid, s_a_ready, s_d_valid, s_d_ready;
    logic [2:0] s_a_bits_opcode, s_a_bits_param; logic [3:0] s_a_bits_size;
    logic [1:0] s_a_bits_source; logic [31:0] s_a_bits_address;
    logic [BB-1:0] s_a_bits_mask; logic [DATA_W-1:0] s_a_bits_data;
    logic [2:0] s_d_bits_opcode; logic [1:0] s_d_bits_param; logic [3:0] s_d_bits_size;
    logic [1:0] s_d_bits_source; logic s_d_bits_sink, s_d_bits_error;
    logic [DATA_W-1:0] s_d_bits_data;
    logic owner, busy, protocol_err;

    tilelink_ul_arbiter #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_bits_opcode(m0_a_bits_opcode),
        .m0_a_bits_param(m0_a_bits_param), .m0_a_bits_size(m0_a_bits_size),
        .m0_a_bits_source(m0_a_bits_source), .m0_a_bits_address(m0_a_bits_address),
        .m0_a_bits_mask(m0_a_bits_mask), .m0_a_bits_data(m0_a_bits_data),
        .m0_d_ready(m0_d_ready), .m0_d_valid(m0_d_valid), .m0_d_bits_opcode(m0_d_bits_opcode),
        .m0_d_bits_param(m0_d_bits_param), .m0_d_bits_size(m0_d_bits_size),
        .m0_d_bits_source(m0_d_bits_source), .m0_d_bits_sink(m0_d_bits_sink),
        .m0_d_bits_data(m0_d_bits_data), .m0_d_bits_error(m0_d_bits_error),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_bits_opcode(m1_a_bits_opcode),
        .m1_a_bits_param(m1_a_bits_param), .m1_a_bits_size(m1_a_bits_size),
        .m1_a_bits_source(m1_a_bits_source), .m1_a_bits_address(m1_a_bits_address),
        .m1_a_bits_mask(m1_a_bits_mask), .m1_a_bits_data(m1_a_bits_data),
        .m1_d_ready(m1_d_ready), .m1_d_valid(m1_d_valid), .m1_d_bits_opcode(m1_d_bits_opcode),
        .m1_d_bits_param(m1_d_bits_param), .m1_d_bits_size(m1_d_bits_size),
        .m1_d_bits_source(m1_d_bits_source), .m1_d_bits_sink(m1_d_bits_sink),
        .m1_d_bits_data(m1_d_bits_data), .m1_d_bits_error(m1_d_bits_error),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_bits_opcode(s_a_bits_opcode),
        .s_a_bits_param(s_a_bits_param), .s_a_bits_size(s_a_bits_size),
        .s_a_bits_source(s_a_bits_source), .s_a_bits_address(s_a_bits_address),
        .s_a_bits_mask(s_a_bits_mask), .s_a_bits_data(s_a_bits_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_bits_opcode(s_d_bits_opcode),
        .s_d_bits_param(s_d_bits_param), .s_d_bits_size(s_d_bits_size),
        .s_d_bits_source(s_d_bits_source), .s_d_bits_sink(s_d_bits_sink),
        .s_d_bits_data(s_d_bits_data), .s_d_bits_error(s_d_bits_error),
        .owner(owner), .busy(busy), .protocol_err(protocol_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        {m0_a_valid, m0_a_bits_opcode, m0_a_bits_param, m0_a_bits_size, m0_a_bits_source} = '0;
        {m1_a_valid, m1_a_bits_opcode, m1_a_bits_param, m1_a_bits_size, m1_a_bits_source} = '0;
        m0_a_bits_address = '0; m0_a_bits_mask = '1; m0_a_bits_data = '0;
        m1_a_bits_address = '0; m1_a_bits_mask = '1; m1_a_bits_data = '0;
        m0_d_ready = 1'b0; m1_d_ready = 1'b0; s_a_ready = 1'b0;
        s_d_valid = 1'b0; s_d_bits_opcode = '0; s_d_bits_param = '0; s_d_bits_size = '0;
        s_d_bits_source = '0; s_d_bits_sink = 1'b0; s_d_bits_data = '0; s_d_bits_error = 1'b0;
    endtask

    task automatic set_m(input int n, input logic v, input logic [2:0] op, input logic [3:0] sz,
                         input logic src, input logic [31:0] addr, input logic [31:0] data);
        if (n == 0) begin
            m0_a_valid = v; m0_a_bits_opcode = op; m0_a_bits_size = sz;
            m0_a_bits_source = src; m0_a_bits_address = addr; m0_a_bits_data = data;
        end else begin
            m1_a_valid = v; m1_a_bits_opcode = op; m1_a_bits_size = sz;
            m1_a_bits_source = src; m1_a_bits_address = addr; m1_a_bits_data = data;
        end
    endtask

    task automatic set_d(input logic v, input logic [1:0] src, input logic [2:0] op, input logic [3:0] sz);
        s_d_valid = v; s_d_bits_source = src; s_d_bits_opcode = op; s_d_bits_size = sz;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic m0v, m1v, sar, sdv; logic [1:0] dsrc; logic m0dr, m1dr;
        logic e_sav, e_m0ar, e_m1ar; logic [1:0] e_src;
        logic e_m0dv, e_m1dv, e_sdr;
    } vec_t;

    function automatic int abeats(input int op, input int sz);
        int b = (sz <= LG) ? 1 : (1 << (sz - LG));
        return (op <= 3) ? b : 1;
    endfunction
    function automatic int dbeats(input int op, input int sz);
        int b = (sz <= LG) ? 1 : (1 << (sz - LG));
        return (op >= 2 && op <= 4) ? b : 1;
    endfunction

    initial begin
        vec_t vt[6];
        logic m_active, m_owner, m_prio, m_err, sel, a_open, afire, dfire, counted;
        int m_a_rem, m_d_rem;
        logic [42:0] act_v, exp_v;

        do_reset();
        #2;
        check("reset_state", {busy, owner, protocol_err, s_a_valid, s_d_ready}, 5'b0);

        // Combinational routing in IDLE with prio=0; inputs are cleared before the next edge.
        vt[0] = '{1'b1,1'b0,1'b1, 1'b1,2'b00,1'b1,1'b0, 1'b1,1'b1,1'b0,2'b01, 1'b1,1'b0,1'b1};
        vt[1] = '{1'b0,1'b1,1'b1, 1'b1,2'b11,1'b1,1'b0, 1'b1,1'b0,1'b1,2'b10, 1'b0,1'b1,1'b0};
        vt[2] = '{1'b1,1'b1,1'b1, 1'b1,2'b10,1'b0,1'b1, 1'b1,1'b1,1'b0,2'b01, 1'b0,1'b1,1'b1};
        vt[3] = '{1'b1,1'b1,1'b0, 1'b0,2'b01,1'b1,1'b0, 1'b1,1'b0,1'b0,2'b01, 1'b0,1'b0,1'b1};
        vt[4] = '{1'b0,1'b1,1'b0, 1'b1,2'b01,1'b0,1'b1, 1'b1,1'b0,1'b0,2'b10, 1'b1,1'b0,1'b0};
        vt[5] = '{1'b1,1'b0,1'b0, 1'b1,2'b10,1'b1,1'b0, 1'b1,1'b0,1'b0,2'b01, 1'b0,1'b1,1'b0};
        for (int i = 0; i < 6; i++) begin
            tick();
            set_m(0, vt[i].m0v, 3'd4, 4'd2, 1'b1, 32'h1000, 32'h0);
            set_m(1, vt[i].m1v, 3'd4, 4'd2, 1'b0, 32'h2000, 32'h0);
            s_a_ready = vt[i].sar; m0_d_ready = vt[i].m0dr; m1_d_ready = vt[i].m1dr;
            set_d(vt[i].sdv, vt[i].dsrc, 3'd1, 4'd2);
            s_d_bits_data = 32'hDEAD_0000 + i;
            #2;
            check($sformatf("vec%0d_a", i), {s_a_valid, m0_a_ready, m1_a_ready, s_a_bits_source},
                  {vt[i].e_sav, vt[i].e_m0ar, vt[i].e_m1ar, vt[i].e_src});
            check($sformatf("vec%0d_addr", i), s_a_bits_address, vt[i].e_src[1] ? 32'h2000 : 32'h1000);
            check($sformatf("vec%0d_d", i), {m0_d_valid, m1_d_valid, s_d_ready, m0_d_bits_source, m1_d_bits_source},
                  {vt[i].e_m0dv, vt[i].e_m1dv, vt[i].e_sdr, vt[i].dsrc[0], vt[i].dsrc[0]});
            check($sformatf("vec%0d_data", i), m1_d_bits_data, 32'hDEAD_0000 + i);
            idle_inputs();
        end

        // Simultaneous requests: m0 wins, m1 waits through m0's D beat.
        tick();
        set_m(0, 1'b1, 3'd4, 4'd2, 1'b0, 32'h100, 32'h0);
        set_m(1, 1'b1, 3'd4, 4'd2, 1'b0, 32'h200, 32'h0);
        s_a_ready = 1'b1; #2;
        check("both_grant", {s_a_valid, m0_a_ready, m1_a_ready, s_a_bits_source}, 5'b1_1_0_00);
        tick(); m0_a_valid = 1'b0; #2;
        check("both_dwait", {s_a_valid, m0_a_ready, m1_a_ready, busy, owner}, 5'b0_0_0_1_0);
        tick(); set_d(1'b1, 2'b00, 3'd1, 4'd2); m0_d_ready = 1'b1; #2;
        check("both_dbeat", {m0_d_valid, m1_d_valid, s_d_ready, m1_a_ready}, 4'b1_0_1_0);
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0); #2;
        check("m1_after", {s_a_valid, m1_a_ready, m0_a_ready, s_a_bits_source, busy}, 6'b1_1_0_10_0);
        tick(); m1_a_valid = 1'b0; #2;
        check("m1_owner", {busy, owner}, 2'b11);
        tick(); set_d(1'b1, 2'b10, 3'd1, 4'd2); m1_d_ready = 1'b1; #2;
        check("m1_dbeat", {m1_d_valid, m0_d_valid, s_d_ready}, 3'b1_0_1);
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0); #2;
        check("m1_done", busy, 1'b0);

        // m0 single Get; afterwards prio favours m1.
        set_m(0, 1'b1, 3'd4, 4'd2, 1'b0, 32'h300, 32'h0); #2;
        check("get_src", {s_a_valid, s_a_bits_source}, 3'b1_00);
        tick(); m0_a_valid = 1'b0; set_d(1'b1, 2'b00, 3'd1, 4'd2); m0_d_ready = 1'b1; #2;
        check("get_d", {m0_d_valid, m1_d_valid, busy}, 3'b1_0_1);
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0); #2;
        check("get_done", busy, 1'b0);

        // m1 PutFull size 4 with m0 contending: four m1 beats, m0 locked out.
        set_m(0, 1'b1, 3'd4, 4'd2, 1'b0, 32'h400, 32'h0);
        set_m(1, 1'b1, 3'd0, 4'd4, 1'b1, 32'h500, 32'hA0);
        s_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m1_a_bits_data = 32'hA0 + i; #2;
            check($sformatf("put_beat%0d", i), {s_a_valid, m0_a_ready, m1_a_ready, s_a_bits_source}, 5'b1_0_1_11);
            check($sformatf("put_data%0d", i), s_a_bits_data, 32'hA0 + i);
            tick();
        end
        m1_a_valid = 1'b0; #2;
        check("put_dwait", {s_a_valid, m0_a_ready, m1_a_ready, busy, owner}, 5'b0_0_0_1_1);
        set_d(1'b1, 2'b11, 3'd0, 4'd4); m1_d_ready = 1'b1; m0_d_ready = 1'b0; #2;
        check("put_ack", {m1_d_valid, m0_d_valid, s_d_ready, m1_d_bits_source}, 4'b1_0_1_1);
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0); #2;
        check("put_m0_next", {s_a_valid, m0_a_ready, m1_a_ready, s_a_bits_source[1]}, 4'b1_1_0_0);
        tick(); m0_a_valid = 1'b0; set_d(1'b1, 2'b00, 3'd1, 4'd2); m0_d_ready = 1'b1;
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0);

        // Get size 3: two D beats, with D back-pressure between them.
        set_m(0, 1'b1, 3'd4, 4'd3, 1'b0, 32'h600, 32'h0); #2;
        check("get3_grant", {s_a_valid, m0_a_ready}, 2'b11);
        tick(); m0_a_valid = 1'b0; set_d(1'b1, 2'b00, 3'd1, 4'd3); m0_d_ready = 1'b1;
        tick(); m0_d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check($sformatf("get3_stall%0d", i), {s_d_ready, m0_d_valid, busy}, 3'b0_1_1);
            tick();
        end
        m0_d_ready = 1'b1; #2;
        check("get3_beat2", {s_d_ready, busy}, 2'b11);
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0); m0_d_ready = 1'b0; #2;
        check("get3_done", busy, 1'b0);

        // Stray D in IDLE: routed, flagged next cycle, sticky.
        set_d(1'b1, 2'b10, 3'd1, 4'd2); m1_d_ready = 1'b1; #2;
        check("stray_route", {m1_d_valid, m0_d_valid, s_d_ready, protocol_err}, 4'b1_0_1_0);
        tick(); set_d(1'b0, 2'b00, 3'd0, 4'd0); #2;
        check("stray_flag", protocol_err, 1'b1);
        tick(); tick();
        check("stray_sticky", protocol_err, 1'b1);

        // Reset in the second beat of a PutFull.
        set_m(0, 1'b1, 3'd0, 4'd4, 1'b0, 32'h700, 32'hB0); s_a_ready = 1'b1;
        tick();
        reset = 1'b1;
        set_m(1, 1'b1, 3'd4, 4'd2, 1'b0, 32'h800, 32'h0);
        set_d(1'b1, 2'b00, 3'd1, 4'd2); m0_d_ready = 1'b1; m1_d_ready = 1'b1; #2;
        check("rst_outs", {s_a_valid, m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid, s_d_ready}, 6'b0);
        tick();
        reset = 1'b0; idle_inputs(); #2;
        check("rst_after", {busy, protocol_err}, 2'b00);

        // Random traffic against a transaction-level model.
        do_reset();
        m_active = 1'b0; m_owner = 1'b0; m_prio = 1'b0; m_err = 1'b0; m_a_rem = 0; m_d_rem = 0;
        for (int c = 0; c < 3000; c++) begin
            set_m(0, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
                  1'($urandom), $urandom, $urandom);
            set_m(1, ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
                  1'($urandom), $urandom, $urandom);
            s_a_ready  = ($urandom_range(0, 3) != 0);
            m0_d_ready = ($urandom_range(0, 3) != 0);
            m1_d_ready = ($urandom_range(0, 3) != 0);
            set_d(($urandom_range(0, 4) < 2),
                  {(($urandom_range(0, 3) == 0) ? ~m_owner : m_owner), 1'($urandom)}, 3'd1, 4'd0);
            #2;
            a_open = !m_active || (m_a_rem > 0);
            sel    = m_active ? m_owner : ((m0_a_valid && m1_a_valid) ? m_prio : m1_a_valid);
            exp_v  = {a_open && (sel ? m1_a_valid : m0_a_valid),
                      a_open && !sel && s_a_ready, a_open && sel && s_a_ready,
                      sel, (sel ? m1_a_bits_source : m0_a_bits_source),
                      (sel ? m1_a_bits_address : m0_a_bits_address),
                      s_d_valid && !s_d_bits_source[1], s_d_valid && s_d_bits_source[1],
                      (s_d_bits_source[1] ? m1_d_ready : m0_d_ready),
                      m_active, m_owner, m_err};
            act_v  = {s_a_valid, m0_a_ready, m1_a_ready, s_a_bits_source, s_a_bits_address,
                      m0_d_valid, m1_d_valid, s_d_ready, busy, owner, protocol_err};
            check($sformatf("rand%0d", c), act_v, exp_v);
            afire   = exp_v[42] && s_a_ready;
            dfire   = s_d_valid && (s_d_bits_source[1] ? m1_d_ready : m0_d_ready);
            counted = dfire && m_active && (m_a_rem == 0) && (s_d_bits_source[1] == m_owner);
            if (dfire && !counted) m_err = 1'b1;
            if (!m_active) begin
                if (afire) begin
                    m_active = 1'b1;
                    m_owner  = sel;
                    m_a_rem  = abeats(int'(sel ? m1_a_bits_opcode : m0_a_bits_opcode),
                                      int'(sel ? m1_a_bits_size : m0_a_bits_size)) - 1;
                    m_d_rem  = dbeats(int'(sel ? m1_a_bits_opcode : m0_a_bits_opcode),
                                      int'(sel ? m1_a_bits_size : m0_a_bits_size));
                end
            end else if (m_a_rem > 0) begin
                if (afire) m_a_rem--;
            end else if (counted) begin
                m_d_rem--;
                if (m_d_rem == 0) begin
                    m_active = 1'b0;
                    m_prio   = ~m_owner;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
